// File: rtl/alu_seq_if.sv
// Request/result bundle between the register-file read ports, alu_seq and the writeback mux.
// slave is the ALU side; master is the control-unit / testbench side.
interface alu_seq_if #(
    parameter int WIDTH       = 16,
    parameter int CONST_WIDTH = 8
);
    logic                   i_valid;
    logic                   o_ready;
    logic [3:0]             i_opcode;
    logic [1:0]             i_extra;
    logic [WIDTH-1:0]       i_data1;
    logic [WIDTH-1:0]       i_data2;
    logic [CONST_WIDTH-1:0] i_const;
    logic                   o_valid;
    logic [WIDTH-1:0]       o_data;
    logic [WIDTH-1:0]       o_data_hi;
    logic                   o_zero;
    logic                   o_carry;
    logic                   o_div_zero;

    modport slave (
        input  i_valid, i_opcode, i_extra, i_data1, i_data2, i_const,
        output o_ready, o_valid, o_data, o_data_hi, o_zero, o_carry, o_div_zero
    );

    modport master (
        output i_valid, i_opcode, i_extra, i_data1, i_data2, i_const,
        input  o_ready, o_valid, o_data, o_data_hi, o_zero, o_carry, o_div_zero
    );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle ADD/SUB/AND/OR/SHIFT/MOVE, iterative unsigned MUL and DIV.
// Results and flags are registered and held until the next completion.
module alu_seq #(
    parameter int WIDTH       = 16,
    parameter int CONST_WIDTH = 8
) (
    input  logic       i_clk,
    input  logic       i_reset,
    alu_seq_if.slave   bus
);

    // state  | meaning
    // S_IDLE | ready; single-cycle ops complete on the accepting edge
    // S_MUL  | shift-add multiply, one multiplier bit per cycle
    // S_DIV  | restoring divide, one quotient bit per cycle
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    localparam int CW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_AND   = 4'h2;
    localparam logic [3:0] OP_OR    = 4'h3;
    localparam logic [3:0] OP_SHIFT = 4'h4;
    localparam logic [3:0] OP_MOVE  = 4'h7;
    localparam logic [3:0] OP_MUL   = 4'hA;
    localparam logic [3:0] OP_DIV   = 4'hB;

    localparam logic [CW-1:0]    CNT_LAST  = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] SHIFT_LIM = WIDTH'(WIDTH);

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_data_hi;
    logic             r_zero;
    logic             r_carry;
    logic             r_div_zero;

    state_t           w_state;
    logic [CW-1:0]    w_cnt;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_hi;
    logic [WIDTH-1:0] w_lo;
    logic             w_valid;
    logic [WIDTH-1:0] w_data;
    logic [WIDTH-1:0] w_data_hi;
    logic             w_zero;
    logic             w_carry;
    logic             w_div_zero;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_shamt;
    logic [WIDTH-1:0] w_shift;
    logic [WIDTH:0]   w_mul_add;
    logic [WIDTH-1:0] w_mul_hi;
    logic [WIDTH-1:0] w_mul_lo;
    logic [WIDTH:0]   w_div_trial;
    logic [WIDTH:0]   w_div_sub;
    logic [WIDTH-1:0] w_div_hi;
    logic [WIDTH-1:0] w_div_lo;

    // Single-cycle datapath; diff[WIDTH] is set exactly when A < B.
    always_comb begin
        w_sum   = {1'b0, bus.i_data1} + {1'b0, bus.i_data2};
        w_diff  = {1'b0, bus.i_data1} - {1'b0, bus.i_data2};
        w_shamt = bus.i_extra[1] ? WIDTH'(bus.i_const) : bus.i_data2;
        if (w_shamt >= SHIFT_LIM) begin
            w_shift = '0;
        end else if (bus.i_extra[0]) begin
            w_shift = bus.i_data1 << w_shamt;
        end else begin
            w_shift = bus.i_data1 >> w_shamt;
        end
    end

    // One iteration of each multi-cycle algorithm, applied to the working registers.
    always_comb begin
        w_mul_add   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
        w_mul_hi    = w_mul_add[WIDTH:1];
        w_mul_lo    = {w_mul_add[0], r_lo[WIDTH-1:1]};

        // Remainder stays below the divisor, so the trial fits in WIDTH+1 bits and the
        // top bit of the subtraction is its sign.
        w_div_trial = {r_hi, r_lo[WIDTH-1]};
        w_div_sub   = w_div_trial - {1'b0, r_b};
        if (w_div_sub[WIDTH]) begin
            w_div_hi = w_div_trial[WIDTH-1:0];
            w_div_lo = {r_lo[WIDTH-2:0], 1'b0};
        end else begin
            w_div_hi = w_div_sub[WIDTH-1:0];
            w_div_lo = {r_lo[WIDTH-2:0], 1'b1};
        end
    end

    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_b        = r_b;
        w_hi       = r_hi;
        w_lo       = r_lo;
        w_valid    = 1'b0;
        w_data     = r_data;
        w_data_hi  = r_data_hi;
        w_zero     = r_zero;
        w_carry    = r_carry;
        w_div_zero = r_div_zero;

        case (r_state)
            S_IDLE: begin
                if (bus.i_valid) begin
                    w_valid    = 1'b1;
                    w_data     = '0;
                    w_data_hi  = '0;
                    w_carry    = 1'b0;
                    w_div_zero = 1'b0;
                    case (bus.i_opcode)
                        OP_ADD: begin
                            w_data  = w_sum[WIDTH-1:0];
                            w_carry = w_sum[WIDTH];
                        end
                        OP_SUB: begin
                            w_data  = w_diff[WIDTH-1:0];
                            w_carry = w_diff[WIDTH];
                        end
                        OP_AND:   w_data = bus.i_data1 & bus.i_data2;
                        OP_OR:    w_data = bus.i_data1 | bus.i_data2;
                        OP_SHIFT: w_data = w_shift;
                        OP_MOVE:  w_data = bus.i_data1;
                        OP_MUL: begin
                            w_valid    = 1'b0;
                            w_data     = r_data;
                            w_data_hi  = r_data_hi;
                            w_carry    = r_carry;
                            w_div_zero = r_div_zero;
                            w_state    = S_MUL;
                            w_cnt      = '0;
                            w_b        = bus.i_data2;
                            w_hi       = '0;
                            w_lo       = bus.i_data1;
                        end
                        OP_DIV: begin
                            if (bus.i_data2 == '0) begin
                                w_data     = '1;
                                w_data_hi  = bus.i_data1;
                                w_div_zero = 1'b1;
                            end else begin
                                w_valid    = 1'b0;
                                w_data     = r_data;
                                w_data_hi  = r_data_hi;
                                w_carry    = r_carry;
                                w_div_zero = r_div_zero;
                                w_state    = S_DIV;
                                w_cnt      = '0;
                                w_b        = bus.i_data2;
                                w_hi       = '0;
                                w_lo       = bus.i_data1;
                            end
                        end
                        default: w_data = '0;
                    endcase
                end
            end
            S_MUL: begin
                w_hi = w_mul_hi;
                w_lo = w_mul_lo;
                if (r_cnt == CNT_LAST) begin
                    w_state    = S_IDLE;
                    w_valid    = 1'b1;
                    w_data     = w_mul_lo;
                    w_data_hi  = w_mul_hi;
                    w_carry    = 1'b0;
                    w_div_zero = 1'b0;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            S_DIV: begin
                w_hi = w_div_hi;
                w_lo = w_div_lo;
                if (r_cnt == CNT_LAST) begin
                    w_state    = S_IDLE;
                    w_valid    = 1'b1;
                    w_data     = w_div_lo;
                    w_data_hi  = w_div_hi;
                    w_carry    = 1'b0;
                    w_div_zero = 1'b0;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            default: w_state = S_IDLE;
        endcase

        if (w_valid) begin
            w_zero = (w_data == '0);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_b        <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_data_hi  <= '0;
            r_zero     <= 1'b1;
            r_carry    <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_b        <= w_b;
            r_hi       <= w_hi;
            r_lo       <= w_lo;
            r_valid    <= w_valid;
            r_data     <= w_data;
            r_data_hi  <= w_data_hi;
            r_zero     <= w_zero;
            r_carry    <= w_carry;
            r_div_zero <= w_div_zero;
        end
    end

    assign bus.o_ready    = (r_state == S_IDLE);
    assign bus.o_valid    = r_valid;
    assign bus.o_data     = r_data;
    assign bus.o_data_hi  = r_data_hi;
    assign bus.o_zero     = r_zero;
    assign bus.o_carry    = r_carry;
    assign bus.o_div_zero = r_div_zero;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: hand-computed vectors for every op class, latency,
// busy-ignore, divide-by-zero and reset abort.
module tb_alu_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(16), .CONST_WIDTH(8)) bus ();

    alu_seq #(.WIDTH(16), .CONST_WIDTH(8)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [1:0] ex,
                         input logic [15:0] a, input logic [15:0] b, input logic [7:0] c);
        bus.i_valid  = 1'b1;
        bus.i_opcode = op;
        bus.i_extra  = ex;
        bus.i_data1  = a;
        bus.i_data2  = b;
        bus.i_const  = c;
    endtask

    task automatic single(input logic [3:0] op, input logic [1:0] ex,
                          input logic [15:0] a, input logic [15:0] b, input logic [7:0] c);
        drive(op, ex, a, b, c);
        step();
        bus.i_valid = 1'b0;
    endtask

    // Issue a request and wait (bounded) for o_valid; lat counts cycles from acceptance.
    task automatic run_multi(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                             input bit inject, output int lat, output int busy);
        drive(op, 2'b00, a, b, 8'h00);
        step();
        bus.i_valid = 1'b0;
        lat  = 1;
        busy = 0;
        while (!bus.o_valid && lat < 40) begin
            if (!bus.o_ready) busy++;
            if (inject && lat == 3) drive(4'h0, 2'b00, 16'h0001, 16'h0001, 8'h00);
            if (inject && lat == 4) bus.i_valid = 1'b0;
            step();
            lat++;
        end
    endtask

    task automatic chk_res(input string tag, input logic [15:0] d, input logic [15:0] hi,
                           input logic z, input logic cy, input logic dz);
        chk({tag, ".valid"}, {31'd0, bus.o_valid}, 32'd1);
        chk({tag, ".data"},  {16'd0, bus.o_data}, {16'd0, d});
        chk({tag, ".hi"},    {16'd0, bus.o_data_hi}, {16'd0, hi});
        chk({tag, ".flags"}, {29'd0, bus.o_zero, bus.o_carry, bus.o_div_zero},
                             {29'd0, z, cy, dz});
    endtask

    initial begin
        int lat;
        int busy;
        int seen;
        bus.i_valid  = 1'b0;
        bus.i_opcode = 4'h0;
        bus.i_extra  = 2'b00;
        bus.i_data1  = '0;
        bus.i_data2  = '0;
        bus.i_const  = '0;

        step();
        step();
        chk("rst.ready", {31'd0, bus.o_ready}, 32'd1);
        chk("rst.valid", {31'd0, bus.o_valid}, 32'd0);
        chk("rst.data",  {bus.o_data_hi, bus.o_data}, 32'h0);
        chk("rst.flags", {29'd0, bus.o_zero, bus.o_carry, bus.o_div_zero}, 32'b100);
        rst = 1'b0;
        step();

        single(4'h0, 2'b00, 16'hFFFF, 16'h0001, 8'h00);
        chk_res("add_ovf", 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0);
        step();
        chk("add_ovf.pulse", {31'd0, bus.o_valid}, 32'd0);
        chk("add_ovf.hold", {16'd0, bus.o_data}, 32'h0);

        single(4'h1, 2'b00, 16'h0003, 16'h0005, 8'h00);
        chk_res("sub_brw", 16'hFFFE, 16'h0000, 1'b0, 1'b1, 1'b0);

        single(4'h4, 2'b11, 16'h0001, 16'h0000, 8'h04);
        chk_res("shl_const", 16'h0010, 16'h0000, 1'b0, 1'b0, 1'b0);
        single(4'h4, 2'b00, 16'h8000, 16'h0004, 8'h00);
        chk_res("shr_b4", 16'h0800, 16'h0000, 1'b0, 1'b0, 1'b0);
        single(4'h4, 2'b00, 16'h8000, 16'h0010, 8'h00);
        chk_res("shr_16", 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);
        single(4'h4, 2'b01, 16'h0001, 16'h0104, 8'h00);
        chk_res("shl_big", 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);

        run_multi(4'hA, 16'h1234, 16'h0100, 1'b1, lat, busy);
        chk("mul1.lat", lat, 32'd17);
        chk("mul1.busy", busy, 32'd16);
        chk("mul1.ready", {31'd0, bus.o_ready}, 32'd1);
        chk_res("mul1", 16'h3400, 16'h0012, 1'b0, 1'b0, 1'b0);
        step();
        chk("mul1.noq", {31'd0, bus.o_valid}, 32'd0);
        chk("mul1.hold", {bus.o_data_hi, bus.o_data}, 32'h0012_3400);

        run_multi(4'hB, 16'd100, 16'd7, 1'b0, lat, busy);
        chk("div1.lat", lat, 32'd17);
        chk_res("div1", 16'd14, 16'd2, 1'b0, 1'b0, 1'b0);

        single(4'hB, 2'b00, 16'h0055, 16'h0000, 8'h00);
        chk("div0.ready", {31'd0, bus.o_ready}, 32'd1);
        chk_res("div0", 16'hFFFF, 16'h0055, 1'b0, 1'b0, 1'b1);

        single(4'h0, 2'b00, 16'h0001, 16'h0002, 8'h00);
        chk_res("add_small", 16'h0003, 16'h0000, 1'b0, 1'b0, 1'b0);

        drive(4'h2, 2'b00, 16'hF0F0, 16'h3C3C, 8'h00);
        step();
        chk_res("b2b_and", 16'h3030, 16'h0000, 1'b0, 1'b0, 1'b0);
        drive(4'h3, 2'b00, 16'hF0F0, 16'h0F00, 8'h00);
        step();
        chk_res("b2b_or", 16'hFFF0, 16'h0000, 1'b0, 1'b0, 1'b0);
        drive(4'h7, 2'b00, 16'hABCD, 16'h1111, 8'h00);
        step();
        bus.i_valid = 1'b0;
        chk_res("b2b_move", 16'hABCD, 16'h0000, 1'b0, 1'b0, 1'b0);

        single(4'h9, 2'b00, 16'h1234, 16'h5678, 8'h00);
        chk_res("op9", 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);

        run_multi(4'hA, 16'hFFFF, 16'hFFFF, 1'b0, lat, busy);
        chk("mul2.lat", lat, 32'd17);
        chk_res("mul2", 16'h0001, 16'hFFFE, 1'b0, 1'b0, 1'b0);

        drive(4'hA, 2'b00, 16'h1234, 16'h0100, 8'h00);
        step();
        bus.i_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("abort.busy", {31'd0, bus.o_ready}, 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort.ready", {31'd0, bus.o_ready}, 32'd1);
        chk("abort.valid", {31'd0, bus.o_valid}, 32'd0);
        chk("abort.data",  {bus.o_data_hi, bus.o_data}, 32'h0);
        chk("abort.flags", {29'd0, bus.o_zero, bus.o_carry, bus.o_div_zero}, 32'b100);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.o_valid) seen++;
            step();
        end
        chk("abort.novalid", seen, 32'd0);

        single(4'h0, 2'b00, 16'h0005, 16'h0006, 8'h00);
        chk_res("post_add", 16'h000B, 16'h0000, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
